// File: rtl/muldiv_sequencer.sv
// Sequencer for the multi-cycle multiply/divide unit: latency counting, HI/LO
// write pulse, protocol checking and PC / IF/ID / ID/EX hazard control.
module muldiv_sequencer #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic clk,
  input  logic reset_n,
  input  logic EX_start,
  input  logic EX_is_div,
  input  logic EX_signed,
  input  logic EX_divisor_zero,
  input  logic EX_flush,
  input  logic ID_muldiv,
  input  logic ID_hilo_use,
  output logic unit_start,
  output logic unit_is_div,
  output logic unit_signed,
  output logic busy,
  output logic hilo_we,
  output logic div0_flag,
  output logic protocol_err,
  output logic PC_LE,
  output logic IFID_LE,
  output logic control_select
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             is_div_q, is_div_d;
  logic             signed_q, signed_d;
  logic             div0_q, div0_d;
  logic             last;
  logic             accept;
  logic             start_req;
  logic             stall;

  assign busy      = (state_q == RUN);
  assign last      = busy && (count_q == '0);
  assign start_req = EX_start && !EX_flush;
  assign accept    = start_req && (!busy || last);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    is_div_d = is_div_q;
    signed_d = signed_q;
    div0_d   = div0_q;
    if (accept) begin
      state_d  = RUN;
      is_div_d = EX_is_div;
      signed_d = EX_signed;
      // A zero divisor finishes in a single cycle; HI/LO contents are undefined.
      if (EX_is_div && EX_divisor_zero) begin
        count_d = '0;
        div0_d  = 1'b1;
      end else begin
        count_d = EX_is_div ? DIV_LOAD : MUL_LOAD;
        div0_d  = 1'b0;
      end
    end else if (last) begin
      state_d = IDLE;
    end else if (busy) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      is_div_q <= 1'b0;
      signed_q <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      is_div_q <= is_div_d;
      signed_q <= signed_d;
      div0_q   <= div0_d;
    end
  end

  // A back-to-back mult/div in ID may proceed on accept; HI/LO readers may not.
  assign stall = (ID_hilo_use && ((busy && !last) || accept)) ||
                 (ID_muldiv && busy && !last);

  assign unit_start     = accept;
  assign unit_is_div    = is_div_q;
  assign unit_signed    = signed_q;
  assign hilo_we        = last;
  assign div0_flag      = div0_q;
  assign protocol_err   = start_req && busy && !last;
  assign PC_LE          = !stall;
  assign IFID_LE        = !stall;
  assign control_select = stall;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: per-cycle vector table plus hand-written
// divide-latency and asynchronous-reset sequences.
module tb_muldiv_sequencer;

  logic clk = 1'b0;
  logic reset_n;
  logic EX_start, EX_is_div, EX_signed, EX_divisor_zero, EX_flush;
  logic ID_muldiv, ID_hilo_use;
  logic unit_start, unit_is_div, unit_signed, busy, hilo_we, div0_flag;
  logic protocol_err, PC_LE, IFID_LE, control_select;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  muldiv_sequencer #(.MUL_CYCLES(4), .DIV_CYCLES(32), .CNT_W(6)) dut (
    .clk(clk), .reset_n(reset_n),
    .EX_start(EX_start), .EX_is_div(EX_is_div), .EX_signed(EX_signed),
    .EX_divisor_zero(EX_divisor_zero), .EX_flush(EX_flush),
    .ID_muldiv(ID_muldiv), .ID_hilo_use(ID_hilo_use),
    .unit_start(unit_start), .unit_is_div(unit_is_div), .unit_signed(unit_signed),
    .busy(busy), .hilo_we(hilo_we), .div0_flag(div0_flag),
    .protocol_err(protocol_err), .PC_LE(PC_LE), .IFID_LE(IFID_LE),
    .control_select(control_select)
  );

  // Output pack: {unit_start, busy, hilo_we, protocol_err, PC_LE, IFID_LE,
  //               control_select, unit_is_div, unit_signed, div0_flag}
  logic [9:0] outs;
  assign outs = {unit_start, busy, hilo_we, protocol_err, PC_LE, IFID_LE,
                 control_select, unit_is_div, unit_signed, div0_flag};

  // Input pack: {EX_start, EX_is_div, EX_signed, EX_divisor_zero, EX_flush,
  //              ID_muldiv, ID_hilo_use}
  typedef struct packed {
    logic [6:0] in;
    logic [9:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic drive(input logic [6:0] in);
    {EX_start, EX_is_div, EX_signed, EX_divisor_zero, EX_flush,
     ID_muldiv, ID_hilo_use} = in;
  endtask

  task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  // Advance to just after the next active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int hilo_seen;

  initial begin
    // MULT, no ID traffic: busy cycles 1-4, hilo_we in cycle 4
    vecs.push_back('{7'b1000000, 10'b1000110000});
    vecs.push_back('{7'b0000000, 10'b0100110000});
    vecs.push_back('{7'b0000000, 10'b0100110000});
    vecs.push_back('{7'b0000000, 10'b0100110000});
    vecs.push_back('{7'b0000000, 10'b0110110000});
    vecs.push_back('{7'b0000000, 10'b0000110000});
    // MULT signed with MFHI held in ID: stall start cycle + cycles 1-3
    vecs.push_back('{7'b1010001, 10'b1000001000});
    vecs.push_back('{7'b0000001, 10'b0100001010});
    vecs.push_back('{7'b0000001, 10'b0100001010});
    vecs.push_back('{7'b0000001, 10'b0100001010});
    vecs.push_back('{7'b0000001, 10'b0110110010});
    vecs.push_back('{7'b0000001, 10'b0000110010});
    // MULT; mult in ID stalls; start in cycle 2 -> protocol_err; back-to-back at last
    vecs.push_back('{7'b1000000, 10'b1000110010});
    vecs.push_back('{7'b0000010, 10'b0100001000});
    vecs.push_back('{7'b1000000, 10'b0101110000});
    vecs.push_back('{7'b0000000, 10'b0100110000});
    vecs.push_back('{7'b1000010, 10'b1110110000});
    vecs.push_back('{7'b0000000, 10'b0100110000});
    vecs.push_back('{7'b0000000, 10'b0100110000});
    vecs.push_back('{7'b0000000, 10'b0100110000});
    vecs.push_back('{7'b0000000, 10'b0110110000});
    vecs.push_back('{7'b0000000, 10'b0000110000});
    // Flushed start with MFHI in ID: nothing happens
    vecs.push_back('{7'b1000101, 10'b0000110000});
    vecs.push_back('{7'b0000000, 10'b0000110000});
    // DIVU by zero: one-cycle op, sticky div0 until next accepted MULT
    vecs.push_back('{7'b1101000, 10'b1000110000});
    vecs.push_back('{7'b0000000, 10'b0110110101});
    vecs.push_back('{7'b0000000, 10'b0000110101});
    vecs.push_back('{7'b1000000, 10'b1000110101});
    vecs.push_back('{7'b0000000, 10'b0100110000});
    vecs.push_back('{7'b0000000, 10'b0100110000});
    vecs.push_back('{7'b0000000, 10'b0100110000});
    vecs.push_back('{7'b0000000, 10'b0110110000});
    vecs.push_back('{7'b0000000, 10'b0000110000});

    drive(7'b0);
    reset_n = 1'b0;
    #12;
    check("reset_state", outs, 10'b0000110000);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step();
      drive(vecs[i].in);
      #1;
      check($sformatf("vec%0d", i), outs, vecs[i].exp);
    end

    // Signed DIV, nonzero divisor: hilo_we only in cycle 32
    step();
    drive(7'b1110000);
    #1;
    check("div_start", outs, 10'b1000110000);
    for (int k = 1; k <= 32; k++) begin
      step();
      drive(7'b0);
      #1;
      check($sformatf("div_cyc%0d", k), outs,
            (k == 32) ? 10'b0110110110 : 10'b0100110110);
    end
    step();
    #1;
    check("div_done", outs, 10'b0000110110);

    // div0_flag cleared by asynchronous reset
    drive(7'b1101000);
    step();
    drive(7'b0);
    step();
    #1;
    check("div0_sticky", outs, 10'b0000110101);
    reset_n = 1'b0;
    #1;
    check("div0_async_rst", outs, 10'b0000110000);
    #3;
    reset_n = 1'b1;

    // Async reset in cycle 10 of a signed DIV with MFHI stalled in ID
    step();
    drive(7'b1110001);
    #1;
    check("rst_div_start", outs, 10'b1000001000);
    for (int k = 1; k <= 10; k++) begin
      step();
      drive(7'b0000001);
    end
    #1;
    check("rst_div_cyc10", outs, 10'b0100001110);
    reset_n = 1'b0;
    #1;
    check("rst_async", outs, 10'b0000110000);
    drive(7'b0);
    step();
    step();
    #2;
    reset_n = 1'b1;
    hilo_seen = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (hilo_we || busy) hilo_seen++;
    end
    n_checks++;
    if (hilo_seen != 0) begin
      n_fail++;
      $display("FAIL post_rst_activity: got %0d busy/hilo_we cycles expected 0", hilo_seen);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Controls the multi-cycle multiply/divide unit and its HI/LO registers in the 5-stage pipeline. It accepts MULT/MULTU/DIV/DIVU issued from EX, runs a cycle counter for the operation latency, and pulses the HI/LO write when the operation completes. It stalls PC and IF/ID and injects a bubble into ID/EX while a younger instruction in ID needs HI/LO or the unit.

Parameters:
MUL_CYCLES, 4, multiply latency in cycles (>=1)
DIV_CYCLES, 32, divide latency in cycles (>=1)
CNT_W, 6, counter width; must satisfy 2**CNT_W > max(MUL_CYCLES, DIV_CYCLES)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
EX_start  input  1  mult/div instruction valid in EX this cycle
EX_is_div  input  1  1 = DIV/DIVU, 0 = MULT/MULTU
EX_signed  input  1  1 = signed variant
EX_divisor_zero  input  1  rt operand == 0 (only meaningful when EX_is_div)
EX_flush  input  1  EX instruction squashed this cycle
ID_muldiv  input  1  mult/div instruction in ID
ID_hilo_use  input  1  MFHI/MFLO/MTHI/MTLO in ID
unit_start  output  1  one-cycle start pulse to the arithmetic unit
unit_is_div  output  1  latched operation type
unit_signed  output  1  latched signedness
busy  output  1  operation in progress
hilo_we  output  1  one-cycle HI/LO write enable
div0_flag  output  1  sticky: last divide had zero divisor
protocol_err  output  1  one-cycle pulse: start arrived while busy
PC_LE  output  1  PC load enable (0 = hold)
IFID_LE  output  1  IF/ID load enable (0 = hold)
control_select  output  1  1 = zero control signals into ID/EX (bubble)

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, reset_n). Asserting reset_n=0 at any time, including mid-operation, forces state IDLE, counter 0, unit_is_div=0, unit_signed=0, div0_flag=0. No hilo_we is issued for the aborted operation.
- States: IDLE, RUN. busy = (state==RUN). last = busy && count==0.
- accept = EX_start && !EX_flush && (state==IDLE || last).
- On accept, at the edge:
  - state<=RUN; unit_is_div<=EX_is_div; unit_signed<=EX_signed.
  - count <= (EX_is_div ? DIV_CYCLES : MUL_CYCLES) - 1.
  - If EX_is_div && EX_divisor_zero: count<=0 and div0_flag<=1. Otherwise div0_flag<=0.
- unit_start = accept (combinational, same cycle as EX_start).
- In RUN with count>0: count decrements each cycle.
- In RUN with count==0 (last):
  - hilo_we=1 for that cycle.
  - next state IDLE, unless accept, in which case RUN is reloaded back-to-back.
- Latency: hilo_we is high in the N-th cycle after the accept edge, where N = the latency loaded (1 for divide-by-zero). busy is high for exactly N cycles.
- Divide-by-zero still asserts hilo_we; the HI/LO contents are architecturally undefined.
- protocol_err = EX_start && !EX_flush && busy && !last. The start is ignored and state is unchanged. This cannot occur with a correct stall; benches treat it as a failure flag.
- EX_flush=1 suppresses accept and protocol_err that cycle.
- stall = (ID_muldiv || ID_hilo_use) && ((busy && !last) || accept).
  - Exception: ID_muldiv alone does not stall on accept, because a second op issues back-to-back when the first reaches last.
  - Exact form: stall = ID_hilo_use && ((busy && !last) || accept)  OR  ID_muldiv && busy && !last.
- PC_LE = IFID_LE = !stall. control_select = stall. All three are combinational.
- Releasing the stall in the last cycle is safe: HI/LO is written at that edge and MFHI/MFLO reads it in EX on the following cycle.

Test Plan:
- MULT with MUL_CYCLES=4, no ID traffic: accept at edge 0 -> busy cycles 1-4, hilo_we only in cycle 4, unit_start high one cycle, PC_LE stays 1.
- MULT then MFHI held in ID: ID_hilo_use=1 from the start cycle -> PC_LE=IFID_LE=0 and control_select=1 for the start cycle plus cycles 1-3; released in cycle 4 (hilo_we cycle).
- DIV signed, DIV_CYCLES=32, divisor nonzero: hilo_we in cycle 32, unit_is_div=1, unit_signed=1, div0_flag=0. Repeat with EX_divisor_zero=1: hilo_we in cycle 1, div0_flag=1 until the next accepted start.
- Back-to-back: second MULT in EX during the last cycle of the first -> accepted with no stall, hilo_we in the last cycle of each op. EX_start in cycle 2 of a busy op -> protocol_err=1, count unaffected.
- EX_start with EX_flush=1 -> no unit_start, busy stays 0, no stall.
- Reset asserted asynchronously in cycle 10 of a DIV -> busy=0 immediately with no clock edge, no hilo_we afterwards, PC_LE=1 and div0_flag=0.
